serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow flip-flop.
- Companion to the adder cells in the arithmetic library. It targets area-critical datapaths where WIDTH-cycle latency is acceptable.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b/bin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result is valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  unsigned borrow-out; 1 when a < b + bin
- ovf  output  1  two's-complement signed overflow
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. rst has priority over every other event in every state.
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, busy = 0.
  - diff = 0, bout = 0, ovf = 0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch a and b into shift registers, bin into the borrow FF, and a[WIDTH-1], b[WIDTH-1] into sign registers. Load counter = WIDTH-1. Go to RUN.
  - in_valid low: remain in IDLE.
- RUN (each edge):
  - Bit cell computes d = a0 ^ b0 ^ brw and brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
  - a and b shift right by 1.
  - d shifts into the result register at the MSB; the result register shifts right.
  - borrow FF <= brw_next.
  - When counter == 0: go to DONE on this edge. Otherwise decrement the counter.
  - in_ready = 0; in_valid is ignored.
- DONE:
  - out_valid = 1; diff = result register; bout = borrow FF.
  - ovf = (sa != sb) & (diff[WIDTH-1] != sa), where sa and sb are the latched sign bits.
  - All outputs are held stable until out_valid & out_ready on an edge. That edge returns the FSM to IDLE.
  - No same-cycle pass-through: in_ready rises on the cycle after the output handshake.
- Latency: the accept edge is E0. Bits are processed on edges E1..EWIDTH. out_valid is high in the cycle after EWIDTH, i.e. WIDTH cycles after the accept edge. Throughput is one operation per WIDTH+2 cycles at best.
- diff/bout/ovf are don't-care when out_valid = 0; they are zero only after reset. The bench checks them only when out_valid = 1.
- Boundary conditions:
  - a == b with bin = 0 gives diff = 0, bout = 0.
  - a = 0, b = 2^WIDTH-1, bin = 1 gives diff = 0, bout = 1.
  - rst during RUN or DONE aborts the operation: the in-flight result is discarded and no out_valid pulse follows.
  - in_valid and out_ready asserted together in DONE: only the output handshake occurs; new operands are accepted at the earliest on the next cycle.

Decomposition:
- Package serial_arith_pkg:
  - state typedef: enum logic [1:0] {IDLE, RUN, DONE}.
  - Counter width constant CNT_W = $clog2(WIDTH), supplied as a function of WIDTH.
- Sub-module full_subtractor: combinational inputs a, b, bin; outputs d, bout (parity and borrow functions). Instantiated once as the serial bit cell.

Test Plan (WIDTH = 8):
- a=8'h5A, b=8'h23, bin=0 -> diff=8'h37, bout=0, ovf=0; out_valid rises exactly 8 cycles after the accept edge.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0.
- a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1 (signed -128 - 1).
- a=8'h10, b=8'h10, bin=1 -> diff=8'hFF, bout=1, ovf=0.
- Backpressure: a=8'h5A, b=8'h23, bin=0, out_ready held low 5 cycles in DONE with in_valid held high:
  - out_valid, diff=8'h37 and bout=0 stay stable; in_ready stays 0.
  - Assert out_ready -> in_ready = 1 on the next cycle; a second op (a=8'h00, b=8'h01) is then accepted and completes with diff=8'hFF, bout=1.
- Abort: assert rst after the 4th RUN edge -> next cycle out_valid=0, busy=0, in_ready=1. A subsequent op a=8'hFF, b=8'h01 then completes with diff=8'hFE, bout=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic cells.
// Holds the control FSM encoding and the counter-width function.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: difference parity and borrow generation.
// Used as the one shared bit cell of the serial subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Operands and result move through valid/ready handshakes.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q;
  logic             sa_q;
  logic             sb_q;
  logic             d_bit;
  logic             brw_nx;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (brw_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (cnt_q == '0)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      brw_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= bin;
            sa_q  <= a[WIDTH-1];
            sb_q  <= b[WIDTH-1];
            cnt_q <= CNT_W'(WIDTH - 1);
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          brw_q <= brw_nx;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = res_q;
  assign bout      = brw_q;
  assign ovf       = (sa_q != sb_q) & (res_q[WIDTH-1] != sa_q);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci);
    a = ai;
    b = bi;
    bin = ci;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic ci, input string tag);
    int n;
    int r;
    int sr;
    logic [31:0] rv;
    logic [W-1:0] ed;
    logic eb;
    logic eo;
    r  = int'(ai) - int'(bi) - int'(ci);
    rv = r;
    ed = rv[W-1:0];
    eb = (int'(ai) < int'(bi) + int'(ci));
    sr = int'($signed(ai)) - int'($signed(bi)) - int'(ci);
    eo = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_latency"}, n, W);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_drain", out_valid, 0);
    check("in_ready_after_drain", in_ready, 1);
  endtask

  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                    input logic ci, input string tag);
    start(ai, bi, ci);
    wait_done(ai, bi, ci, tag);
    drain();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);

    op(8'h5A, 8'h23, 1'b0, "basic");
    op(8'h00, 8'h01, 1'b0, "wrap");
    op(8'h80, 8'h01, 1'b0, "sovf");
    op(8'h10, 8'h10, 1'b1, "eqbin");
    op(8'h6C, 8'h6C, 1'b0, "equal");
    op(8'h00, 8'hFF, 1'b1, "maxb");

    start(8'h5A, 8'h23, 1'b0);
    wait_done(8'h5A, 8'h23, 1'b0, "bp");
    a = 8'h00;
    b = 8'h01;
    bin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, 8'h37);
      check("bp_bout", bout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_out_valid", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    check("bp_hs_busy", busy, 0);
    start(8'h00, 8'h01, 1'b0);
    wait_done(8'h00, 8'h01, 1'b0, "bp2");
    drain();

    start(8'hC3, 8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
    op(8'hFF, 8'h01, 1'b0, "post_abort");

    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      op(ra, rb, rc, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
